// File: rtl/result_packet_tx.sv
// Result packet transmitter: captures Black-Scholes results on the rising edge of BS_DONE,
// queues them in a small FIFO and streams each as a two-beat valid/ready packet.
module result_packet_tx #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   BS_DONE,
  input  logic [31:0]            opt_id,
  input  logic [31:0]            otype,
  input  logic [31:0]            price,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [31:0]            tx_data,
  output logic                   tx_last,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } tx_state_e;

  tx_state_e        state, state_next;
  logic             prev_bs_done;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             capture, pop, push, drop;

  logic [31:0] word0_mem [DEPTH];
  logic [31:0] price_mem [DEPTH];

  // Only opt_id[31:1] and otype[0] are carried in the packet.
  logic unused_input_bits;
  assign unused_input_bits = ^{opt_id[0], otype[31:1]};

  assign full = (count == CNT_W'(DEPTH));

  always_comb begin
    capture = BS_DONE && !prev_bs_done;
    pop     = (state == SEND1) && tx_ready;
    // A capture while full survives only if the head leaves at the same edge.
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      prev_bs_done <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      prev_bs_done <= BS_DONE;
      count        <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers and
  // count define which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clock) begin
    if (push) begin
      word0_mem[wr_ptr] <= {opt_id[31:1], otype[0]};
      price_mem[wr_ptr] <= price;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (count != '0) state_next = SEND0;
      SEND0:   if (tx_ready)    state_next = SEND1;
      SEND1:   if (tx_ready)    state_next = (count_next != '0) ? SEND0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on the state register and the FIFO head, never on tx_ready.
  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    unique case (state)
      SEND0: begin
        tx_valid = 1'b1;
        tx_data  = word0_mem[rd_ptr];
      end
      SEND1: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = price_mem[rd_ptr];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_result_packet_tx.sv
// Directed testbench for result_packet_tx: drives inputs just after the rising edge,
// checks outputs on the falling edge and logs transferred beats for order checks.
module tb_result_packet_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        BS_DONE = 1'b0;
  logic [31:0] opt_id = '0;
  logic [31:0] otype = '0;
  logic [31:0] price = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;
  logic        full;
  logic        overflow;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  logic [32:0] beat_q[$];
  int          stamp_q[$];

  result_packet_tx #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .BS_DONE(BS_DONE), .opt_id(opt_id), .otype(otype),
    .price(price), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .full(full), .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  // A beat seen valid&&ready at the falling edge transfers at the following rising edge.
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      beat_q.push_back({tx_last, tx_data});
      stamp_q.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic do_reset();
    cyc(); reset = 1'b1; BS_DONE = 1'b0; tx_ready = 1'b0;
    cyc();
    cyc(); reset = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] id, input logic [31:0] ot, input logic [31:0] pr);
    cyc(); BS_DONE = 1'b1; opt_id = id; otype = ot; price = pr;
    cyc(); BS_DONE = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(); mid();
      if (!tx_valid && count == 3'd0) begin done = 1; break; end
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s_drain: FIFO not empty after 40 cycles, count=%0d", name, count); end
  endtask

  task automatic test_reset();
    cyc(); cyc(); mid();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", tx_data); end
    n_cmp++; if (tx_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", tx_last); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    cyc(); reset = 1'b0;
  endtask

  task automatic test_single();
    beat_q.delete(); stamp_q.delete();
    cyc(); BS_DONE = 1'b1; opt_id = 32'h12345679; otype = 32'd1; price = 32'h40490FDB; tx_ready = 1'b1;
    mid();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL single_c0_count: got %0d want 0", count); end
    cyc(); BS_DONE = 1'b0; mid();
    n_cmp++; if ({tx_valid, count} !== {1'b0, 3'd1}) begin n_bad++; $display("FAIL single_c1: got valid=%b count=%0d want valid=0 count=1", tx_valid, count); end
    cyc(); mid();
    n_cmp++; if ({tx_valid, tx_last, tx_data} !== {2'b10, 32'h12345679}) begin n_bad++; $display("FAIL single_beat0: got v=%b l=%b d=%h want v=1 l=0 d=12345679", tx_valid, tx_last, tx_data); end
    cyc(); mid();
    n_cmp++; if ({tx_valid, tx_last, tx_data} !== {2'b11, 32'h40490FDB}) begin n_bad++; $display("FAIL single_beat1: got v=%b l=%b d=%h want v=1 l=1 d=40490fdb", tx_valid, tx_last, tx_data); end
    cyc(); mid();
    n_cmp++; if ({tx_valid, count} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL single_after: got valid=%b count=%0d want 0/0", tx_valid, count); end
  endtask

  task automatic test_held();
    int peak = 0;
    logic [32:0] exp_q[$];
    beat_q.delete(); stamp_q.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(); BS_DONE = 1'b1; opt_id = 32'hABCD0001; otype = 32'h2; price = 32'hC0000000;
      mid(); if (int'(count) > peak) peak = int'(count);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(); BS_DONE = 1'b0;
      mid(); if (int'(count) > peak) peak = int'(count);
    end
    n_cmp++; if (peak != 1) begin n_bad++; $display("FAIL held_peak_count: got %0d want 1", peak); end
    exp_q = '{{1'b0, 32'hABCD0000}, {1'b1, 32'hC0000000}};
    n_cmp++; if (beat_q.size() != exp_q.size()) begin n_bad++; $display("FAIL held_beats: got %0d beats want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++; if (beat_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL held_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] exp_q[$];
    beat_q.delete(); stamp_q.delete();
    tx_ready = 1'b0;
    pulse(32'h00001110, 32'd1, 32'h11111111);
    pulse(32'h00002220, 32'd0, 32'h22222222);
    mid();
    for (int i = 0; i < 6; i++) begin
      cyc(); mid();
      n_cmp++; if ({tx_valid, tx_last, tx_data} !== {2'b10, 32'h00001111}) begin n_bad++; $display("FAIL bp_stall%0d: got v=%b l=%b d=%h want v=1 l=0 d=00001111", i, tx_valid, tx_last, tx_data); end
    end
    n_cmp++; if (beat_q.size() != 0) begin n_bad++; $display("FAIL bp_no_transfer: got %0d beats want 0", beat_q.size()); end
    cyc(); tx_ready = 1'b1; mid();
    cyc(); mid();
    n_cmp++; if ({tx_valid, tx_last, tx_data} !== {2'b11, 32'h11111111}) begin n_bad++; $display("FAIL bp_beat1_next: got v=%b l=%b d=%h want v=1 l=1 d=11111111", tx_valid, tx_last, tx_data); end
    drain("bp");
    exp_q = '{{1'b0, 32'h00001111}, {1'b1, 32'h11111111}, {1'b0, 32'h00002220}, {1'b1, 32'h22222222}};
    n_cmp++; if (beat_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_beats: got %0d beats want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++; if (beat_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_fill_overflow();
    logic [32:0] exp_q[$];
    logic [31:0] id;
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      id = 32'(2 * (k + 1));
      pulse(id, 32'd0, 32'h40000000 | id);
      mid();
      if (k == 2) begin
        n_cmp++; if ({full, count} !== {1'b0, 3'd3}) begin n_bad++; $display("FAIL fill_3rd: got full=%b count=%0d want 0/3", full, count); end
      end
      if (k == 3) begin
        n_cmp++; if ({full, overflow, count} !== {2'b10, 3'd4}) begin n_bad++; $display("FAIL fill_4th: got full=%b ovf=%b count=%0d want 1/0/4", full, overflow, count); end
      end
      if (k == 4) begin
        n_cmp++; if ({full, overflow, count} !== {2'b11, 3'd4}) begin n_bad++; $display("FAIL fill_5th_drop: got full=%b ovf=%b count=%0d want 1/1/4", full, overflow, count); end
      end
    end
    beat_q.delete(); stamp_q.delete();
    drain("fill");
    for (int k = 0; k < 4; k++) begin
      id = 32'(2 * (k + 1));
      exp_q.push_back({1'b0, id});
      exp_q.push_back({1'b1, 32'h40000000 | id});
    end
    n_cmp++; if (beat_q.size() != exp_q.size()) begin n_bad++; $display("FAIL fill_beats: got %0d beats want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++; if (beat_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fill_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
    end
    if (stamp_q.size() == 8) begin
      n_cmp++; if (stamp_q[7] - stamp_q[0] != 7) begin n_bad++; $display("FAIL fill_no_gap: got span %0d cycles want 7", stamp_q[7] - stamp_q[0]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_sticky_overflow: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    logic [32:0] exp_q[$];
    logic [31:0] id;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      id = 32'h20 + 32'(2 * k);
      pulse(id, 32'd0, 32'h50000000 | id);
    end
    beat_q.delete(); stamp_q.delete();
    cyc(); tx_ready = 1'b1; mid();
    cyc(); tx_ready = 1'b1; BS_DONE = 1'b1; opt_id = 32'h28; otype = 32'd0; price = 32'h50000028; mid();
    n_cmp++; if ({tx_valid, tx_last, count} !== {2'b11, 3'd4}) begin n_bad++; $display("FAIL fullpop_send1: got v=%b l=%b count=%0d want 1/1/4", tx_valid, tx_last, count); end
    cyc(); tx_ready = 1'b0; BS_DONE = 1'b0; mid();
    n_cmp++; if ({full, overflow, count} !== {2'b10, 3'd4}) begin n_bad++; $display("FAIL fullpop_accept: got full=%b ovf=%b count=%0d want 1/0/4", full, overflow, count); end
    drain("fullpop");
    for (int k = 0; k < 5; k++) begin
      id = 32'h20 + 32'(2 * k);
      exp_q.push_back({1'b0, id});
      exp_q.push_back({1'b1, 32'h50000000 | id});
    end
    n_cmp++; if (beat_q.size() != exp_q.size()) begin n_bad++; $display("FAIL fullpop_beats: got %0d beats want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++; if (beat_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fullpop_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] exp_q[$];
    bit seen_valid = 0;
    do_reset();
    for (int k = 0; k < 5; k++) pulse(32'h40 + 32'(2 * k), 32'd0, 32'h60000000);
    mid();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_overflow: got %b want 1", overflow); end
    cyc(); tx_ready = 1'b1;
    cyc();
    cyc();
    cyc(); tx_ready = 1'b0; reset = 1'b1; mid();
    n_cmp++; if ({tx_valid, tx_last, count} !== {2'b11, 3'd3}) begin n_bad++; $display("FAIL rstmid_in_send1: got v=%b l=%b count=%0d want 1/1/3", tx_valid, tx_last, count); end
    cyc(); reset = 1'b0; mid();
    n_cmp++; if ({tx_valid, count, overflow, full} !== {1'b0, 3'd0, 2'b00}) begin n_bad++; $display("FAIL rstmid_after: got v=%b count=%0d ovf=%b full=%b want 0/0/0/0", tx_valid, count, overflow, full); end
    beat_q.delete(); stamp_q.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); mid();
      if (tx_valid) seen_valid = 1;
    end
    n_cmp++; if (seen_valid || beat_q.size() != 0) begin n_bad++; $display("FAIL rstmid_quiet: got valid_seen=%b beats=%0d want 0/0", seen_valid, beat_q.size()); end
    pulse(32'h50, 32'd1, 32'h55555555);
    drain("rstmid");
    exp_q = '{{1'b0, 32'h00000051}, {1'b1, 32'h55555555}};
    n_cmp++; if (beat_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rstmid_beats: got %0d beats want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++; if (beat_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_backpressure();
    test_fill_overflow();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_packet_tx.md
# result_packet_tx

- Transmit-side counterpart of the input packet register.
- Captures each Black-Scholes result (option id, option type, price) when the BS core signals completion, and buffers results in a small FIFO.
- Sends each result downstream as a two-beat, 32-bit packet over a valid/ready handshake.
- Sits between the BS pricing core and the outbound host/network interface.

## Interface
Parameters:
- DEPTH, 4: number of buffered result entries; power of two, at least 2.

Ports:
- clock  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- BS_DONE  in  1  BS result valid level; may stay high for several cycles.
- opt_id  in  32  option id from the BS core; bit 0 is ignored.
- otype  in  32  option type; only bit 0 is used.
- price  in  32  IEEE-754 single result price.
- tx_ready  in  1  downstream accepts the current beat.
- tx_valid  out  1  a beat is presented on tx_data.
- tx_data  out  32  beat payload.
- tx_last  out  1  high on the second (final) beat of a packet.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; a result was dropped.
- count  out  $clog2(DEPTH)+1  current number of FIFO entries.

## Operation
- **Capture**
  - A register prevBS_DONE holds BS_DONE delayed one cycle.
  - A capture event is BS_DONE && !prevBS_DONE. Only the rising edge captures, never a held-high level.
  - Each entry stores {opt_id[31:1], otype[0]} (32 bits) and price (32 bits).
- **FIFO**
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - The occupancy counter ranges over 0..DEPTH.
  - full = (count == DEPTH).
- **Capture while full**
  - If a pop completes in the same cycle, the entry is accepted and count stays at DEPTH.
  - Otherwise the entry is dropped, overflow is set to 1, and FIFO contents and pointers are unchanged.
- **Simultaneous push and pop** when not full: count is unchanged and both pointers advance.
- **Transmit FSM**, states IDLE, SEND0, SEND1:
  - IDLE: tx_valid = 0. Moves to SEND0 at the next edge when count != 0.
  - SEND0: tx_valid = 1, tx_data = head word 0 ({opt_id[31:1], otype}), tx_last = 0. On tx_ready, moves to SEND1.
  - SEND1: tx_valid = 1, tx_data = head price, tx_last = 1. On tx_ready, the head is popped. Next state is SEND0 if count after the pop is nonzero, else IDLE.
- **Handshake rules**
  - A beat transfers on any edge where tx_valid && tx_ready.
  - While tx_valid = 1 and tx_ready = 0, tx_data and tx_last must hold stable.
  - tx_valid never drops before its beat transfers.
  - Packets are never interleaved or truncated.
- **Overflow** clears only on reset.

## Timing
- **Reset** (synchronous, takes priority over everything):
  - tx_valid = 0, tx_data = 0, tx_last = 0, full = 0, overflow = 0, count = 0.
  - prevBS_DONE = 0, state = IDLE, pointers = 0.
  - Reset during SEND0 or SEND1 aborts the packet; no partial beat follows.
- **Capture-to-output latency**, with the FIFO empty, the FSM in IDLE and BS_DONE rising in cycle c:
  - The entry is written at the end of cycle c.
  - count = 1 in cycle c+1.
  - tx_valid = 1 with word 0 in cycle c+2.
- **Throughput**: with tx_ready held high, one beat per cycle and one packet per 2 cycles, with no IDLE gap between queued packets.
- tx_valid, tx_data and tx_last are driven from registered state and the FIFO head only. There is no combinational path from tx_ready to tx_valid.
- A capture and the FIFO pop both complete at the same edge they occur in; count reflects both on the next cycle.

## Test plan
- **Single result.** Stimulus: BS_DONE pulses 1 cycle with opt_id=32'h12345679, otype=1, price=32'h40490FDB; tx_ready held 1. Required response:
  - tx_valid rises 2 cycles after the pulse.
  - Beat 0 = 32'h12345679 with tx_last=0.
  - Beat 1 = 32'h40490FDB with tx_last=1.
  - Then tx_valid=0 and count=0.
- **Held level.** Stimulus: BS_DONE held high for 10 cycles. Required response: exactly one packet is sent and count peaks at 1.
- **Backpressure.** Stimulus: tx_ready=0 for 7 cycles during SEND0, then 1. Required response:
  - tx_data holds the same word 0 through the stall.
  - Beat 1 follows on the next cycle.
  - Order is preserved.
- **Fill and overflow.** Stimulus: tx_ready=0; 5 captures with opt_id 2, 4, 6, 8, 10. Required response:
  - full=1 after the 4th capture.
  - The 5th is dropped and overflow=1.
  - After releasing tx_ready, exactly ids 2, 4, 6, 8 are sent in that order, as back-to-back packets with no gap.
- **Capture while full with pop.** Stimulus: FIFO full; a capture coincides with the SEND1 handshake. Required response:
  - The entry is accepted, count stays 4 and overflow stays 0.
  - The new entry is sent last.
- **Reset mid-packet.** Stimulus: reset asserted during SEND1 with 3 entries queued. Required response:
  - Next cycle: tx_valid=0, count=0, overflow=0.
  - No beat is emitted until a new capture occurs.
